pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline built around the EX ALU block. Detects load-use hazards between the ID and EX stages and inserts one bubble for each. Issues IF/ID flushes for taken branches and jumps resolved in ID. Sequences the halt opcode (6'b111111): blocks fetch, drains the back end, then reports completion. Sits beside the pipeline registers and drives their enable/flush inputs. Also keeps stall and flush performance counters.

Parameters:
DRAIN_CYCLES, 2, cycles after halt reaches EX before halt_done asserts (covers MEM and WB)
CNT_WIDTH, 32, width of the stall and flush performance counters

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
id_instruction  input  32  instruction currently in the IF/ID register
id_branch_taken  input  1  beq/bne comparison in ID resolved as taken
ex_ALUopcode  input  6  opcode of the instruction in ID/EX
ex_writeEnable  input  1  write-back enable of the instruction in ID/EX
ex_writeAddress  input  5  destination register of the instruction in ID/EX
pc_enable  output  1  PC may update this cycle
if_id_enable  output  1  IF/ID register may load
if_id_flush  output  1  IF/ID register loads a NOP (32'h0) instead
id_ex_flush  output  1  ID/EX register loads a bubble (opcode 0, funct 0, writeEnable 0)
halted  output  1  state is DRAIN or HALTED
halt_done  output  1  pipeline fully drained; testbench may dump memory
stall_count  output  CNT_WIDTH  number of load-use bubbles inserted, saturating
flush_count  output  CNT_WIDTH  number of IF/ID flushes issued, saturating

Behaviour:
- State machine states: RUN, DRAIN, HALTED. The state register and counters are sequential. All control outputs are combinational from state and current inputs (zero latency).
- Reset, checked synchronously on each edge:
  - state=RUN, drain counter=0, stall_count=0, flush_count=0.
  - While reset is high: pc_enable=0, if_id_enable=0, if_id_flush=1, id_ex_flush=1, halted=0, halt_done=0.
  - Reset mid-DRAIN or mid-HALTED returns to RUN on the next edge.
- Operand decode of id_instruction:
  - op = [31:26], rs = [25:21], rt = [20:16], funct = [5:0].
  - uses_rs: every opcode except j (000010), jal (000011) and halt (111111). For R-type (op 0), also excluded when funct is sll/srl/sra (000000/000010/000011).
  - uses_rt: op 0 (R-type), beq (000100), bne (000101), sw (101011).
- Load-use hazard (hz), evaluated in RUN only. All of the following must hold:
  - ex_ALUopcode == 6'b100011 (lw)
  - ex_writeEnable == 1
  - ex_writeAddress != 0
  - (uses_rs && rs == ex_writeAddress) || (uses_rt && rt == ex_writeAddress)
- Control flow request (cf), evaluated in RUN only. Any of the following:
  - id_branch_taken
  - op == j or jal
  - op == 0 && funct == 6'b001000 (jr)
- Priority in RUN: halt entry > hz > cf > normal.
  - hz: pc_enable=0, if_id_enable=0, if_id_flush=0, id_ex_flush=1. stall_count increments.
  - cf && !hz: pc_enable=1, if_id_enable=1, if_id_flush=1, id_ex_flush=0. flush_count increments.
  - hz && cf together: stall wins. The branch is re-evaluated next cycle with forwarded data, so only one flush is ever counted per branch.
  - normal: pc_enable=1, if_id_enable=1, both flushes 0.
- Halt entry: in RUN with ex_ALUopcode == 6'b111111.
  - Outputs that cycle: pc_enable=0, if_id_enable=0, if_id_flush=1, id_ex_flush=1.
  - Next state DRAIN, drain counter=0.
  - Takes priority over hz and cf; neither counter increments.
- DRAIN:
  - pc_enable=0, if_id_enable=0, if_id_flush=1, id_ex_flush=1, halted=1.
  - Drain counter increments each cycle. When it equals DRAIN_CYCLES-1, next state is HALTED.
- HALTED: same outputs as DRAIN, plus halt_done=1. Sticky until reset.
- Counters saturate at all-ones and never wrap. They hold their value in DRAIN and HALTED.
- Inputs are ignored in DRAIN and HALTED.

Decomposition:
- Shared package (mips_pkg): opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_HALT), funct constants (FN_JR, FN_SLL, FN_SRL, FN_SRA), and the state enum typedef.
- One sub-module: sat_counter (parameter WIDTH; ports inc, clear, count), instantiated twice.
- Operand-use decode stays inline.

Test Plan:
1. Load-use stall: lw $3 in EX (writeEnable=1, addr=3) with ID add $5,$3,$4 -> exactly one cycle of pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_count 0->1. Next cycle, with EX=bubble, outputs are normal.
2. No false stall:
   - lw to $0 with ID rs=0 -> no stall.
   - lw $3 with ID sll $5,$3,2 (rt=3 is used) -> stall.
   - lw $3 with ID j -> no stall; flush_count+1.
3. Branch: id_branch_taken=1 with EX non-lw -> if_id_flush=1, pc_enable=1 for one cycle; flush_count=1. jr $31 (op 0, funct 001000) -> same response.
4. Simultaneous: lw $2 in EX with ID beq $2,$1 taken -> stall only (stall_count+1, flush_count unchanged). Next cycle, with hz cleared and branch still taken -> flush; flush_count+1.
5. Halt: ex_ALUopcode=111111 -> halted=1 from the next cycle; halt_done=1 exactly DRAIN_CYCLES cycles after entry and stays high. Lw/branch inputs applied afterwards change no output or counter.
6. Reset mid-DRAIN: assert reset one cycle after halt entry -> the next cycle shows state RUN, halted=0, counters=0. Pre-load stall_count=all-ones and apply one more hazard -> it stays all-ones.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and the hazard sequencer state type for the
// 5-stage MIPS pipeline.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Sticks at all-ones instead of wrapping; clear has priority over inc.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clock) begin
      if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, IF/ID flushes for ID-resolved control
// flow, and the halt drain sequence, plus stall/flush performance counters.
module pipeline_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          id_instruction,
   input  logic                 id_branch_taken,
   input  logic [5:0]           ex_ALUopcode,
   input  logic                 ex_writeEnable,
   input  logic [4:0]           ex_writeAddress,
   output logic                 pc_enable,
   output logic                 if_id_enable,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 halted,
   output logic                 halt_done,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] flush_count
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   state_t             r_state;
   state_t             w_stateNext;
   logic [DRAIN_W-1:0] r_drainCnt;
   logic [DRAIN_W-1:0] w_drainCntNext;

   logic [5:0] w_op;
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic [5:0] w_funct;
   logic       w_usesRs;
   logic       w_usesRt;
   logic       w_exIsLw;
   logic       w_hz;
   logic       w_cf;
   logic       w_stallInc;
   logic       w_flushInc;
   logic       w_unusedBits;

   assign w_op    = id_instruction[31:26];
   assign w_rs    = id_instruction[25:21];
   assign w_rt    = id_instruction[20:16];
   assign w_funct = id_instruction[5:0];

   // Immediate/rd/shamt bits never influence hazard detection.
   assign w_unusedBits = ^id_instruction[15:6];

   // Shift-immediate R-types put their source in rt only; rs is a don't-care.
   always_comb begin
      w_usesRs = 1'b1;
      if ((w_op == OP_J) || (w_op == OP_JAL) || (w_op == OP_HALT)) begin
         w_usesRs = 1'b0;
      end else if ((w_op == OP_RTYPE) &&
                   ((w_funct == FN_SLL) || (w_funct == FN_SRL) || (w_funct == FN_SRA))) begin
         w_usesRs = 1'b0;
      end
   end

   assign w_usesRt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                     (w_op == OP_BNE)   || (w_op == OP_SW);

   assign w_exIsLw = (ex_ALUopcode == OP_LW) && ex_writeEnable && (ex_writeAddress != 5'd0);

   assign w_hz = w_exIsLw &&
                 ((w_usesRs && (w_rs == ex_writeAddress)) ||
                  (w_usesRt && (w_rt == ex_writeAddress)));

   assign w_cf = id_branch_taken || (w_op == OP_J) || (w_op == OP_JAL) ||
                 ((w_op == OP_RTYPE) && (w_funct == FN_JR));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_drainCnt <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_drainCnt <= w_drainCntNext;
      end
   end

   // A stall beats a flush: the branch is re-resolved next cycle with
   // forwarded data, so each branch is only ever counted once.
   always_comb begin
      w_stateNext    = r_state;
      w_drainCntNext = r_drainCnt;
      pc_enable      = 1'b0;
      if_id_enable   = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      halted         = 1'b0;
      halt_done      = 1'b0;
      w_stallInc     = 1'b0;
      w_flushInc     = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (ex_ALUopcode == OP_HALT) begin
               w_stateNext    = ST_DRAIN;
               w_drainCntNext = '0;
            end else if (w_hz) begin
               if_id_flush = 1'b0;
               id_ex_flush = 1'b1;
               w_stallInc  = 1'b1;
            end else if (w_cf) begin
               pc_enable    = 1'b1;
               if_id_enable = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b0;
               w_flushInc   = 1'b1;
            end else begin
               pc_enable    = 1'b1;
               if_id_enable = 1'b1;
               if_id_flush  = 1'b0;
               id_ex_flush  = 1'b0;
            end
         end
         ST_DRAIN: begin
            halted = 1'b1;
            if (r_drainCnt == DRAIN_LAST) begin
               w_stateNext = ST_HALTED;
            end else begin
               w_drainCntNext = r_drainCnt + DRAIN_W'(1);
            end
         end
         ST_HALTED: begin
            halted    = 1'b1;
            halt_done = 1'b1;
         end
         default: begin
            w_stateNext = ST_RUN;
         end
      endcase

      if (reset) begin
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         halted       = 1'b0;
         halt_done    = 1'b0;
         w_stallInc   = 1'b0;
         w_flushInc   = 1'b0;
      end
   end

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_stallCounter (
      .clock (clock),
      .inc   (w_stallInc),
      .clear (reset),
      .count (stall_count)
   );

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_flushCounter (
      .clock (clock),
      .inc   (w_flushInc),
      .clear (reset),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; counters are built
// narrow so that saturation is reachable in a short run.
module tb_pipeline_hazard_ctrl;

   localparam int CW = 4;

   localparam logic [5:0] CTL_RESET  = 6'b001100;
   localparam logic [5:0] CTL_NORMAL = 6'b110000;
   localparam logic [5:0] CTL_STALL  = 6'b000100;
   localparam logic [5:0] CTL_FLUSH  = 6'b111000;
   localparam logic [5:0] CTL_HENTRY = 6'b001100;
   localparam logic [5:0] CTL_DRAIN  = 6'b001110;
   localparam logic [5:0] CTL_HALTED = 6'b001111;

   logic          clock;
   logic          reset;
   logic [31:0]   idInstruction;
   logic          idBranchTaken;
   logic [5:0]    exOpcode;
   logic          exWriteEnable;
   logic [4:0]    exWriteAddress;
   logic          pcEnable;
   logic          ifIdEnable;
   logic          ifIdFlush;
   logic          idExFlush;
   logic          haltedOut;
   logic          haltDone;
   logic [CW-1:0] stallCount;
   logic [CW-1:0] flushCount;

   int testsRun;
   int testsFailed;

   pipeline_hazard_ctrl #(
      .DRAIN_CYCLES (2),
      .CNT_WIDTH    (CW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .id_instruction  (idInstruction),
      .id_branch_taken (idBranchTaken),
      .ex_ALUopcode    (exOpcode),
      .ex_writeEnable  (exWriteEnable),
      .ex_writeAddress (exWriteAddress),
      .pc_enable       (pcEnable),
      .if_id_enable    (ifIdEnable),
      .if_id_flush     (ifIdFlush),
      .id_ex_flush     (idExFlush),
      .halted          (haltedOut),
      .halt_done       (haltDone),
      .stall_count     (stallCount),
      .flush_count     (flushCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [5:0] ctlVec();
      return {pcEnable, ifIdEnable, ifIdFlush, idExFlush, haltedOut, haltDone};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's inputs mid-cycle and let the combinational outputs settle.
   task automatic applyStimulus(input logic [31:0] instr, input logic br,
                                input logic [5:0] op, input logic we,
                                input logic [4:0] addr);
      @(negedge clock);
      idInstruction  = instr;
      idBranchTaken  = br;
      exOpcode       = op;
      exWriteEnable  = we;
      exWriteAddress = addr;
      #1;
   endtask

   logic [31:0] addR3;
   logic [31:0] sllR3;
   logic [31:0] jmp;
   logic [31:0] beq12;
   logic [31:0] beq21;
   logic [31:0] jr31;
   logic [31:0] addiR3;

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      addR3  = mkR(5'd3, 5'd4, 5'd5, 5'd0, 6'b100000);
      sllR3  = mkR(5'd0, 5'd3, 5'd5, 5'd2, 6'b000000);
      jmp    = mkI(6'b000010, 5'd3, 5'd3, 16'h0040);
      beq12  = mkI(6'b000100, 5'd1, 5'd2, 16'h0004);
      beq21  = mkI(6'b000100, 5'd2, 5'd1, 16'h0004);
      jr31   = mkR(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000);
      addiR3 = mkI(6'b001000, 5'd1, 5'd3, 16'h0001);

      reset = 1'b1;
      applyStimulus(addR3, 1'b1, 6'b100011, 1'b1, 5'd3);
      checkOutput("reset_ctl", 32'(ctlVec()), 32'(CTL_RESET));
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("reset_stall_cnt", 32'(stallCount), 32'd0);
      checkOutput("reset_flush_cnt", 32'(flushCount), 32'd0);
      reset = 1'b0;

      applyStimulus(addR3, 1'b0, 6'b100011, 1'b1, 5'd3);
      checkOutput("lw_use_ctl", 32'(ctlVec()), 32'(CTL_STALL));
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("after_bubble_ctl", 32'(ctlVec()), 32'(CTL_NORMAL));
      checkOutput("stall_cnt_1", 32'(stallCount), 32'd1);

      applyStimulus(mkR(5'd0, 5'd4, 5'd5, 5'd0, 6'b100000), 1'b0, 6'b100011, 1'b1, 5'd0);
      checkOutput("lw_r0_ctl", 32'(ctlVec()), 32'(CTL_NORMAL));
      applyStimulus(addR3, 1'b0, 6'b100011, 1'b0, 5'd3);
      checkOutput("lw_no_we_ctl", 32'(ctlVec()), 32'(CTL_NORMAL));
      applyStimulus(addiR3, 1'b0, 6'b100011, 1'b1, 5'd3);
      checkOutput("addi_rt_dest_ctl", 32'(ctlVec()), 32'(CTL_NORMAL));
      applyStimulus(sllR3, 1'b0, 6'b100011, 1'b1, 5'd3);
      checkOutput("sll_rt_ctl", 32'(ctlVec()), 32'(CTL_STALL));
      applyStimulus(jmp, 1'b0, 6'b100011, 1'b1, 5'd3);
      checkOutput("j_after_lw_ctl", 32'(ctlVec()), 32'(CTL_FLUSH));
      checkOutput("stall_cnt_2", 32'(stallCount), 32'd2);
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("flush_cnt_1", 32'(flushCount), 32'd1);

      applyStimulus(beq12, 1'b1, 6'd0, 1'b1, 5'd7);
      checkOutput("beq_taken_ctl", 32'(ctlVec()), 32'(CTL_FLUSH));
      applyStimulus(jr31, 1'b0, 6'd0, 1'b1, 5'd7);
      checkOutput("jr_ctl", 32'(ctlVec()), 32'(CTL_FLUSH));
      checkOutput("flush_cnt_2", 32'(flushCount), 32'd2);
      applyStimulus(beq21, 1'b1, 6'b100011, 1'b1, 5'd2);
      checkOutput("beq_hz_ctl", 32'(ctlVec()), 32'(CTL_STALL));
      checkOutput("flush_cnt_3", 32'(flushCount), 32'd3);
      applyStimulus(beq21, 1'b1, 6'd0, 1'b0, 5'd0);
      checkOutput("beq_retry_ctl", 32'(ctlVec()), 32'(CTL_FLUSH));
      checkOutput("stall_cnt_3", 32'(stallCount), 32'd3);
      checkOutput("flush_cnt_held", 32'(flushCount), 32'd3);

      applyStimulus(beq12, 1'b1, 6'b111111, 1'b1, 5'd3);
      checkOutput("halt_entry_ctl", 32'(ctlVec()), 32'(CTL_HENTRY));
      checkOutput("flush_cnt_4", 32'(flushCount), 32'd4);
      applyStimulus(addR3, 1'b1, 6'b100011, 1'b1, 5'd3);
      checkOutput("drain1_ctl", 32'(ctlVec()), 32'(CTL_DRAIN));
      applyStimulus(jmp, 1'b1, 6'b100011, 1'b1, 5'd3);
      checkOutput("drain2_ctl", 32'(ctlVec()), 32'(CTL_DRAIN));
      applyStimulus(addR3, 1'b1, 6'b100011, 1'b1, 5'd3);
      checkOutput("halted_ctl", 32'(ctlVec()), 32'(CTL_HALTED));
      applyStimulus(jr31, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("halted_sticky_ctl", 32'(ctlVec()), 32'(CTL_HALTED));
      checkOutput("halted_stall_cnt", 32'(stallCount), 32'd3);
      checkOutput("halted_flush_cnt", 32'(flushCount), 32'd4);

      reset = 1'b1;
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("reset_from_halted_ctl", 32'(ctlVec()), 32'(CTL_RESET));
      reset = 1'b0;
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("run_after_reset_ctl", 32'(ctlVec()), 32'(CTL_NORMAL));
      applyStimulus(addR3, 1'b0, 6'b100011, 1'b1, 5'd3);
      applyStimulus(jmp, 1'b0, 6'd0, 1'b0, 5'd0);
      applyStimulus(addR3, 1'b0, 6'b111111, 1'b0, 5'd0);
      checkOutput("halt_entry2_ctl", 32'(ctlVec()), 32'(CTL_HENTRY));
      checkOutput("pre_reset_stall_cnt", 32'(stallCount), 32'd1);
      reset = 1'b1;
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("reset_in_drain_ctl", 32'(ctlVec()), 32'(CTL_RESET));
      reset = 1'b0;
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("run_after_drain_rst_ctl", 32'(ctlVec()), 32'(CTL_NORMAL));
      checkOutput("drain_rst_stall_cnt", 32'(stallCount), 32'd0);
      checkOutput("drain_rst_flush_cnt", 32'(flushCount), 32'd0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(addR3, 1'b0, 6'b100011, 1'b1, 5'd3);
      end
      applyStimulus(addR3, 1'b0, 6'b100011, 1'b1, 5'd3);
      checkOutput("stall_cnt_14", 32'(stallCount), 32'd14);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(addR3, 1'b0, 6'b100011, 1'b1, 5'd3);
      end
      checkOutput("stall_cnt_saturated", 32'(stallCount), 32'd15);
      applyStimulus(addR3, 1'b0, 6'd0, 1'b0, 5'd0);
      checkOutput("stall_cnt_no_wrap", 32'(stallCount), 32'd15);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
